// File: rtl/int_fp_mul_pkg.sv
// Shared types and constants for the INT8/FP16 pipelined multiplier.
// Covers mode encodings, FP16 constants, flag bit positions and pipeline payloads.
package int_fp_mul_pkg;

    typedef enum logic [1:0] {
        MODE_U8   = 2'b00,
        MODE_S8   = 2'b01,
        MODE_FP16 = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    localparam int          BIAS    = 15;
    localparam logic [15:0] QNAN    = 16'h7E00;
    localparam logic [15:0] POS_INF = 16'h7C00;

    // out_flags = {invalid, overflow, underflow, inexact}
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    // Decoded operands as held in stage 1; cls/invalid describe the FP16 result class.
    typedef struct packed {
        mode_e             mode;
        logic              sign;
        logic signed [7:0] exp;
        fp_class_e         cls;
        logic              invalid;
        logic signed [11:0] op_a;
        logic signed [11:0] op_b;
    } dec_t;

    // Payload after the shared multiplier.
    typedef struct packed {
        mode_e             mode;
        logic              sign;
        logic signed [7:0] exp;
        fp_class_e         cls;
        logic              invalid;
        logic [21:0]       prod;
    } prod_t;

endpackage

// File: rtl/fp16_mul_round.sv
// Normalises and rounds (nearest-even) a 22-bit FP16 significand product.
// Produces the signed result including overflow-to-inf and flush-to-zero underflow.
module fp16_mul_round
    import int_fp_mul_pkg::*;
(
    input  logic [21:0]       prod,
    input  logic signed [7:0] exp_in,
    input  logic              sign,
    output logic [15:0]       res,
    output logic [3:0]        flags
);

    logic              hi;
    logic              guard;
    logic              rnd;
    logic              sticky;
    logic              inexact;
    logic              round_up;
    logic [10:0]       kept;
    logic [11:0]       sum;
    logic [9:0]        mant;
    logic signed [7:0] exp_n;
    logic signed [7:0] exp_r;

    always_comb begin
        hi       = prod[21];
        kept     = hi ? prod[21:11] : prod[20:10];
        guard    = hi ? prod[10] : prod[9];
        rnd      = hi ? prod[9] : prod[8];
        sticky   = hi ? (|prod[8:0]) : (|prod[7:0]);
        exp_n    = hi ? (exp_in + 8'sd1) : exp_in;
        inexact  = guard | rnd | sticky;
        round_up = guard & (rnd | sticky | kept[0]);
        sum      = {1'b0, kept} + {11'd0, round_up};
        // A carry out of the significand leaves 1.000..., so the mantissa becomes zero.
        exp_r    = sum[11] ? (exp_n + 8'sd1) : exp_n;
        mant     = sum[11] ? sum[10:1] : sum[9:0];

        flags = '0;
        res   = {sign, exp_r[4:0], mant};
        if (exp_r >= 8'sd31) begin
            res                   = {sign, POS_INF[14:0]};
            flags[FLAG_OVERFLOW]  = 1'b1;
            flags[FLAG_INEXACT]   = 1'b1;
        end else if (exp_r <= 8'sd0) begin
            res                   = {sign, 15'd0};
            flags[FLAG_UNDERFLOW] = 1'b1;
            flags[FLAG_INEXACT]   = 1'b1;
        end else begin
            flags[FLAG_INEXACT]   = inexact;
        end
    end

endmodule

// File: rtl/int_fp_mul_pipe.sv
// Pipelined INT8 (unsigned/signed) / FP16 multiplier with valid/ready handshake.
// One shared signed 12x12 multiplier serves both integer and FP16 significand products.
module int_fp_mul_pipe
    import int_fp_mul_pkg::*;
#(
    parameter int STAGES = 2    // legal 2..4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_mode,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_c,
    output logic [3:0]  out_flags
);

    logic        advance;
    logic [4:0]  ea, eb;
    logic [9:0]  ma, mb;
    logic        a_zero, a_inf, a_nan;
    logic        b_zero, b_inf, b_nan;
    dec_t        dec;
    dec_t        s1_reg;
    logic        s1_valid_reg;
    logic signed [21:0] mul_a, mul_b, mul_p;
    prod_t       mid_data;
    prod_t       rnd_data;
    logic        rnd_valid;
    logic [15:0] fp_res;
    logic [3:0]  fp_flags;
    logic [15:0] res_c;
    logic [3:0]  res_f;

    assign advance  = ~(out_valid & ~out_ready);
    assign in_ready = advance;

    always_comb begin
        ea     = in_a[14:10];
        eb     = in_b[14:10];
        ma     = in_a[9:0];
        mb     = in_b[9:0];
        // Subnormals have exponent zero and are flushed to signed zero here.
        a_zero = (ea == 5'd0);
        b_zero = (eb == 5'd0);
        a_inf  = (ea == 5'h1F) && (ma == 10'd0);
        b_inf  = (eb == 5'h1F) && (mb == 10'd0);
        a_nan  = (ea == 5'h1F) && (ma != 10'd0);
        b_nan  = (eb == 5'h1F) && (mb != 10'd0);

        dec         = '0;
        dec.mode    = mode_e'(in_mode);
        dec.sign    = in_a[15] ^ in_b[15];
        dec.exp     = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 8'(BIAS);
        dec.cls     = NORM;
        dec.invalid = 1'b0;
        if (a_nan || b_nan) begin
            dec.cls = NAN;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            dec.cls     = NAN;
            dec.invalid = 1'b1;
        end else if (a_inf || b_inf) begin
            dec.cls = INF;
        end else if (a_zero || b_zero) begin
            dec.cls = ZERO;
        end

        case (mode_e'(in_mode))
            MODE_U8: begin
                dec.op_a = {4'b0000, in_a[7:0]};
                dec.op_b = {4'b0000, in_b[7:0]};
            end
            MODE_S8: begin
                dec.op_a = {{4{in_a[7]}}, in_a[7:0]};
                dec.op_b = {{4{in_b[7]}}, in_b[7:0]};
            end
            default: begin
                dec.op_a = {2'b01, ma};
                dec.op_b = {2'b01, mb};
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_reg       <= '0;
        end else if (advance) begin
            s1_valid_reg <= in_valid;
            s1_reg       <= dec;
        end
    end

    // Low 22 bits of the signed product: exact for FP16 significands, and the
    // low 16 bits are the correct INT8 product in both integer modes.
    assign mul_a = 22'(s1_reg.op_a);
    assign mul_b = 22'(s1_reg.op_b);
    assign mul_p = mul_a * mul_b;

    always_comb begin
        mid_data         = '0;
        mid_data.mode    = s1_reg.mode;
        mid_data.sign    = s1_reg.sign;
        mid_data.exp     = s1_reg.exp;
        mid_data.cls     = s1_reg.cls;
        mid_data.invalid = s1_reg.invalid;
        mid_data.prod    = mul_p;
    end

    generate
        if (STAGES > 2) begin : g_slices
            prod_t slice_data  [STAGES-2];
            logic  slice_valid [STAGES-2];

            for (genvar gi = 0; gi < STAGES - 2; gi++) begin : g_slice
                prod_t src_data;
                logic  src_valid;

                if (gi == 0) begin : g_first
                    assign src_data  = mid_data;
                    assign src_valid = s1_valid_reg;
                end else begin : g_next
                    assign src_data  = slice_data[gi-1];
                    assign src_valid = slice_valid[gi-1];
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        slice_valid[gi] <= 1'b0;
                        slice_data[gi]  <= '0;
                    end else if (advance) begin
                        slice_valid[gi] <= src_valid;
                        slice_data[gi]  <= src_data;
                    end
                end
            end

            assign rnd_data  = slice_data[STAGES-3];
            assign rnd_valid = slice_valid[STAGES-3];
        end else begin : g_direct
            assign rnd_data  = mid_data;
            assign rnd_valid = s1_valid_reg;
        end
    endgenerate

    fp16_mul_round u_round (
        .prod   (rnd_data.prod),
        .exp_in (rnd_data.exp),
        .sign   (rnd_data.sign),
        .res    (fp_res),
        .flags  (fp_flags)
    );

    always_comb begin
        res_c = '0;
        res_f = '0;
        case (rnd_data.mode)
            MODE_U8, MODE_S8: res_c = rnd_data.prod[15:0];
            MODE_FP16: begin
                case (rnd_data.cls)
                    NAN: begin
                        res_c               = QNAN;
                        res_f[FLAG_INVALID] = rnd_data.invalid;
                    end
                    INF:  res_c = {rnd_data.sign, POS_INF[14:0]};
                    ZERO: res_c = {rnd_data.sign, 15'd0};
                    default: begin
                        res_c = fp_res;
                        res_f = fp_flags;
                    end
                endcase
            end
            default: res_f[FLAG_INVALID] = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_c     <= '0;
            out_flags <= '0;
        end else if (advance) begin
            out_valid <= rnd_valid;
            out_c     <= res_c;
            out_flags <= res_f;
        end
    end

endmodule
